lcd_message_sequencer: RTL

LCD_MESSAGE_SEQUENCER -- requirements
Module: lcd_message_sequencer

---
 rtl/lcd_message_sequencer_if.sv | 23 ++
 rtl/lcd_message_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lcd_message_sequencer_if.sv
// Handshake and BRAM/LCD bus bundle between the message sequencer and its neighbours.
interface lcd_message_sequencer_if;
  logic        start;
  logic        send_lower;
  logic        send_upper;
  logic [7:0]  char_data;
  logic [10:0] bram_addr;
  logic        fsm_enable;
  logic        lcd_rs;
  logic [3:0]  lcd_data;
  logic        busy;
  logic        done;

  modport slave (
    input  start, send_lower, send_upper, char_data,
    output bram_addr, fsm_enable, lcd_rs, lcd_data, busy, done
  );

  modport master (
    output start, send_lower, send_upper, char_data,
    input  bram_addr, fsm_enable, lcd_rs, lcd_data, busy, done
  );
endinterface

// File: rtl/lcd_message_sequencer.sv
// Walks a two-line message out of character BRAM as LCD nibbles, paced by the timing FSM.
module lcd_message_sequencer #(
  parameter int MSG_LEN  = 32,
  parameter int LINE_LEN = 16
) (
  input logic                     clk_i,
  input logic                     reset_i,
  lcd_message_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD_L1 = 3'd1;
  localparam logic [2:0] S_LINE1  = 3'd2;
  localparam logic [2:0] S_CMD_L2 = 3'd3;
  localparam logic [2:0] S_LINE2  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam bit          TWO_LINES   = (MSG_LEN > LINE_LEN);
  localparam logic [10:0] LINE1_LAST  = TWO_LINES ? 11'(LINE_LEN - 1) : 11'(MSG_LEN - 1);
  localparam logic [10:0] MSG_LAST    = 11'(MSG_LEN - 1);
  localparam logic [10:0] LINE2_FIRST = 11'(LINE_LEN);

  logic [2:0]  state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic        flag_q, flag_d;
  logic        rs_q, rs_d;
  logic [3:0]  data_q, data_d;
  logic [7:0]  byte_d;
  logic        in_byte;

  assign in_byte = (state_q == S_CMD_L1) || (state_q == S_LINE1) ||
                   (state_q == S_CMD_L2) || (state_q == S_LINE2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    flag_d  = flag_q;
    // send_upper wins over a coincident send_lower
    if (in_byte) begin
      if (bus.send_upper) flag_d = 1'b0;
      else if (bus.send_lower) flag_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CMD_L1;
          addr_d  = '0;
          flag_d  = 1'b0;
        end
      end
      S_CMD_L1: begin
        if (bus.send_upper) begin
          state_d = S_LINE1;
          addr_d  = '0;
        end
      end
      S_LINE1: begin
        if (bus.send_upper) begin
          if (addr_q == LINE1_LAST) begin
            state_d = TWO_LINES ? S_CMD_L2 : S_FINISH;
            addr_d  = TWO_LINES ? addr_q : 11'd0;
          end else begin
            addr_d = addr_q + 11'd1;
          end
        end
      end
      S_CMD_L2: begin
        if (bus.send_upper) begin
          state_d = S_LINE2;
          addr_d  = LINE2_FIRST;
        end
      end
      S_LINE2: begin
        if (bus.send_upper) begin
          if (addr_q == MSG_LAST) begin
            state_d = S_FINISH;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 11'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        flag_d  = 1'b0;
      end
    endcase
  end

  // Output registers follow the next state so command nibbles appear on state entry.
  always_comb begin
    byte_d = 8'h00;
    case (state_d)
      S_CMD_L1: byte_d = 8'h80;
      S_CMD_L2: byte_d = 8'hC0;
      S_LINE1,
      S_LINE2:  byte_d = bus.char_data;
      default:  byte_d = 8'h00;
    endcase
    rs_d   = (state_d == S_LINE1) || (state_d == S_LINE2);
    data_d = flag_d ? byte_d[3:0] : byte_d[7:4];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      flag_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign bus.bram_addr  = addr_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_data   = data_q;
  assign bus.busy       = in_byte;
  assign bus.fsm_enable = in_byte;
  assign bus.done       = (state_q == S_FINISH);

endmodule
